// File: rtl/register_bus_arbiter.sv
// register_bus_arbiter
// Round-robin arbiter that shares one 16-bit register bus (address, latch
// strobe, write data) among N masters using a Request/Grant mutex handshake.
// The granted master's signals are muxed onto the bus only while in GRANT,
// and every hand-over passes through a RELEASE dead cycle and an IDLE cycle.
// Optional feature: define ARB_TIMEOUT_EN to enable the hold-time watchdog,
// which force-releases a master after Timeout consecutive GRANT cycles and
// blocks it until its Request has been seen low.
module register_bus_arbiter #(
  parameter int N           = 4,
  parameter int IdxBits     = 2,
  parameter int TimeoutBits = 16,
  parameter int Timeout     = 50000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [N-1:0]         Request,
  output logic [N-1:0]         Grant,
  input  logic [16*N-1:0]      Address_In,
  input  logic [N-1:0]         Latch_In,
  input  logic [8*N-1:0]       DataIn_In,
  output logic [15:0]          Bus_Address,
  output logic                 Bus_Latch,
  output logic [7:0]           Bus_DataIn,
  output logic                 Busy,
  output logic [IdxBits-1:0]   Owner,
  output logic                 Timeout_Flag
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t               state_reg;
  logic [N-1:0]         grant_reg;
  logic [IdxBits-1:0]   owner_reg;
  logic [IdxBits-1:0]   pointer_reg;
  logic [IdxBits-1:0]   pointer_next;
  logic                 busy_reg;

  logic [N-1:0]         eligible;
  logic                 pick_found;
  logic [IdxBits-1:0]   pick_idx;
  logic [N-1:0]         pick_onehot;
  logic                 owner_request;
  logic                 release_now;
  logic                 timeout_fire;
  logic                 bus_active;

  logic [15:0]          addr_arr [N];
  logic [7:0]           data_arr [N];

  // Split the flat per-master buses into indexable arrays
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign addr_arr[gi] = Address_In[16*gi +: 16];
      assign data_arr[gi] = DataIn_In[8*gi +: 8];
    end
  endgenerate

  assign owner_request = Request[owner_reg];

`ifdef ARB_TIMEOUT_EN
  logic [TimeoutBits-1:0] hold_cnt_reg;
  logic [N-1:0]           blocked_reg;
  logic                   timeout_flag_reg;

  assign timeout_fire = (state_reg == ST_GRANT) && owner_request &&
                        (hold_cnt_reg == TimeoutBits'(Timeout - 1));
  assign eligible     = Request & ~blocked_reg;
  assign Timeout_Flag = timeout_flag_reg;

  // Count consecutive GRANT cycles; zero whenever not granting so entry starts at 0
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hold_cnt_reg <= '0;
    end else if (state_reg != ST_GRANT) begin
      hold_cnt_reg <= '0;
    end else begin
      hold_cnt_reg <= hold_cnt_reg + 1'b1;
    end
  end

  // One-cycle pulse marking a forced release
  always_ff @(posedge Clk) begin
    if (Reset) begin
      timeout_flag_reg <= 1'b0;
    end else begin
      timeout_flag_reg <= timeout_fire;
    end
  end

  // A force-released master stays ineligible until its Request is seen low
  generate
    for (gi = 0; gi < N; gi++) begin : g_blocked
      always_ff @(posedge Clk) begin
        if (Reset) begin
          blocked_reg[gi] <= 1'b0;
        end else if (timeout_fire && (owner_reg == IdxBits'(gi))) begin
          blocked_reg[gi] <= 1'b1;
        end else if (!Request[gi]) begin
          blocked_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate
`else
  localparam int unused_timeout_cfg = Timeout + TimeoutBits;

  assign timeout_fire = 1'b0;
  assign eligible     = Request;
  assign Timeout_Flag = 1'b0;
`endif

  // Round-robin pick: first eligible index at or after the pointer, else wrap below it
  always_comb begin
    logic               hi_found;
    logic               lo_found;
    logic [IdxBits-1:0] hi_idx;
    logic [IdxBits-1:0] lo_idx;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        if (i >= int'(pointer_reg)) begin
          hi_found = 1'b1;
          hi_idx   = IdxBits'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IdxBits'(i);
        end
      end
    end
    pick_found = hi_found | lo_found;
    pick_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Decode the picked index to a one-hot grant vector
  always_comb begin
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
  end

  // Pointer wraps at N, not at 2**IdxBits, so the departing owner gets lowest priority
  assign pointer_next = (owner_reg == IdxBits'(N - 1)) ? '0 : owner_reg + 1'b1;

  assign release_now = (state_reg == ST_GRANT) && (!owner_request || timeout_fire);

  // Arbitration FSM: IDLE -> GRANT -> RELEASE -> IDLE with registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg   <= ST_IDLE;
      grant_reg   <= '0;
      owner_reg   <= '0;
      pointer_reg <= '0;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_found) begin
            state_reg <= ST_GRANT;
            grant_reg <= pick_onehot;
            owner_reg <= pick_idx;
            busy_reg  <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            state_reg   <= ST_RELEASE;
            grant_reg   <= '0;
            busy_reg    <= 1'b0;
            pointer_reg <= pointer_next;
          end
        end
        ST_RELEASE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
          grant_reg <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Only the owner drives the bus, and never while reset is asserted
  assign bus_active  = (state_reg == ST_GRANT) && !Reset;
  assign Bus_Address = bus_active ? addr_arr[owner_reg] : 16'h0000;
  assign Bus_DataIn  = bus_active ? data_arr[owner_reg] : 8'h00;
  assign Bus_Latch   = bus_active & Latch_In[owner_reg];

  assign Grant = grant_reg;
  assign Owner = owner_reg;
  assign Busy  = busy_reg;

endmodule

// File: tb/tb_register_bus_arbiter.sv
// Testbench for register_bus_arbiter: a per-cycle vector table covering
// reset state, single grant, round-robin order and latch muxing, followed by
// hand-written sequences for reset mid-grant, hand-over timing and hold time.
module tb_register_bus_arbiter;

  localparam int N = 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [N-1:0]  Request;
  logic [N-1:0]  Grant;
  logic [16*N-1:0] Address_In;
  logic [N-1:0]  Latch_In;
  logic [8*N-1:0] DataIn_In;
  logic [15:0]   Bus_Address;
  logic          Bus_Latch;
  logic [7:0]    Bus_DataIn;
  logic          Busy;
  logic [1:0]    Owner;
  logic          Timeout_Flag;

  int check_count = 0;
  int pass_count  = 0;

  register_bus_arbiter #(
    .N(N),
    .IdxBits(2),
    .TimeoutBits(16),
    .Timeout(8)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Request(Request),
    .Grant(Grant),
    .Address_In(Address_In),
    .Latch_In(Latch_In),
    .DataIn_In(DataIn_In),
    .Bus_Address(Bus_Address),
    .Bus_Latch(Bus_Latch),
    .Bus_DataIn(Bus_DataIn),
    .Busy(Busy),
    .Owner(Owner),
    .Timeout_Flag(Timeout_Flag)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  latch;
    logic [3:0]  exp_grant;
    logic        exp_busy;
    logic [1:0]  exp_owner;
    logic        exp_latch;
    logic [15:0] exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs [$];

  task automatic add_vec(input logic rst, input logic [3:0] req, input logic [3:0] latch,
                         input logic [3:0] g, input logic busy, input logic [1:0] own,
                         input logic lat, input logic [15:0] addr, input logic [7:0] data);
    vec_t v;
    v.rst = rst; v.req = req; v.latch = latch;
    v.exp_grant = g; v.exp_busy = busy; v.exp_owner = own;
    v.exp_latch = lat; v.exp_addr = addr; v.exp_data = data;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset      = 1'b1;
    Request    = '0;
    Latch_In   = '0;
    Address_In = {16'h0143, 16'h0142, 16'h0141, 16'h0140};
    DataIn_In  = {8'h5B, 8'h5A, 8'h59, 8'h58};

    //       rst req      latch    grant    busy own lat addr     data
    // reset state, single grant and release
    add_vec(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 16'h0000, 8'h00);
    add_vec(0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 0, 16'h0000, 8'h00);
    add_vec(0, 4'b0001, 4'b0001, 4'b0001, 1, 0, 1, 16'h0140, 8'h58);
    add_vec(0, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 16'h0140, 8'h58);
    add_vec(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 16'h0000, 8'h00);
    add_vec(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 16'h0000, 8'h00);
    // round robin 0,1,2,3,0 with all requesting
    add_vec(0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 16'h0000, 8'h00);
    add_vec(0, 4'b1111, 4'b0000, 4'b0001, 1, 0, 0, 16'h0140, 8'h58);
    add_vec(0, 4'b1111, 4'b0000, 4'b0001, 1, 0, 0, 16'h0140, 8'h58);
    add_vec(0, 4'b1110, 4'b0000, 4'b0001, 1, 0, 0, 16'h0140, 8'h58);
    add_vec(0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 16'h0000, 8'h00);
    add_vec(0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 16'h0000, 8'h00);
    add_vec(0, 4'b1111, 4'b0000, 4'b0010, 1, 1, 0, 16'h0141, 8'h59);
    add_vec(0, 4'b1111, 4'b0000, 4'b0010, 1, 1, 0, 16'h0141, 8'h59);
    add_vec(0, 4'b1101, 4'b0000, 4'b0010, 1, 1, 0, 16'h0141, 8'h59);
    add_vec(0, 4'b1111, 4'b0000, 4'b0000, 0, 1, 0, 16'h0000, 8'h00);
    add_vec(0, 4'b1111, 4'b0000, 4'b0000, 0, 1, 0, 16'h0000, 8'h00);
    add_vec(0, 4'b1111, 4'b0000, 4'b0100, 1, 2, 0, 16'h0142, 8'h5A);
    add_vec(0, 4'b1111, 4'b0000, 4'b0100, 1, 2, 0, 16'h0142, 8'h5A);
    add_vec(0, 4'b1011, 4'b0000, 4'b0100, 1, 2, 0, 16'h0142, 8'h5A);
    add_vec(0, 4'b1111, 4'b0000, 4'b0000, 0, 2, 0, 16'h0000, 8'h00);
    add_vec(0, 4'b1111, 4'b0000, 4'b0000, 0, 2, 0, 16'h0000, 8'h00);
    add_vec(0, 4'b1111, 4'b0000, 4'b1000, 1, 3, 0, 16'h0143, 8'h5B);
    add_vec(0, 4'b1111, 4'b0000, 4'b1000, 1, 3, 0, 16'h0143, 8'h5B);
    add_vec(0, 4'b0111, 4'b0000, 4'b1000, 1, 3, 0, 16'h0143, 8'h5B);
    add_vec(0, 4'b1111, 4'b0000, 4'b0000, 0, 3, 0, 16'h0000, 8'h00);
    add_vec(0, 4'b1111, 4'b0000, 4'b0000, 0, 3, 0, 16'h0000, 8'h00);
    add_vec(0, 4'b1111, 4'b0000, 4'b0001, 1, 0, 0, 16'h0140, 8'h58);
    add_vec(0, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 16'h0140, 8'h58);
    add_vec(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 16'h0000, 8'h00);
    add_vec(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 16'h0000, 8'h00);
    // owner 2 drives the bus; non-owner latch never reaches it
    add_vec(0, 4'b0100, 4'b0000, 4'b0000, 0, 0, 0, 16'h0000, 8'h00);
    add_vec(0, 4'b0100, 4'b0101, 4'b0100, 1, 2, 1, 16'h0142, 8'h5A);
    add_vec(0, 4'b0100, 4'b0001, 4'b0100, 1, 2, 0, 16'h0142, 8'h5A);
    add_vec(0, 4'b0000, 4'b0000, 4'b0100, 1, 2, 0, 16'h0142, 8'h5A);
    add_vec(0, 4'b0000, 4'b0100, 4'b0000, 0, 2, 0, 16'h0000, 8'h00);
    add_vec(0, 4'b0000, 4'b0000, 4'b0000, 0, 2, 0, 16'h0000, 8'h00);

    tick();
    tick();

    foreach (vecs[i]) begin
      Reset    = vecs[i].rst;
      Request  = vecs[i].req;
      Latch_In = vecs[i].latch;
      #1;
      $display("vec %0d: req=%b latch=%b grant=%b owner=%0d busy=%b", i, Request, Latch_In, Grant, Owner, Busy);
      check($sformatf("v%0d grant", i), 32'(Grant), 32'(vecs[i].exp_grant));
      check($sformatf("v%0d busy", i), 32'(Busy), 32'(vecs[i].exp_busy));
      check($sformatf("v%0d owner", i), 32'(Owner), 32'(vecs[i].exp_owner));
      check($sformatf("v%0d bus_latch", i), 32'(Bus_Latch), 32'(vecs[i].exp_latch));
      check($sformatf("v%0d bus_addr", i), 32'(Bus_Address), 32'(vecs[i].exp_addr));
      check($sformatf("v%0d bus_data", i), 32'(Bus_DataIn), 32'(vecs[i].exp_data));
      check($sformatf("v%0d timeout_flag", i), 32'(Timeout_Flag), 32'd0);
      tick();
    end

    // Reset asserted mid-grant with the owner's latch high
    Request = 4'b0010;
    tick();
    check("rst grant_before", 32'(Grant), 32'h2);
    Latch_In = 4'b0010;
    #1;
    check("rst latch_before", 32'(Bus_Latch), 32'h1);
    Reset = 1'b1;
    #1;
    check("rst latch_in_reset_cycle", 32'(Bus_Latch), 32'h0);
    tick();
    $display("seq reset: grant=%b busy=%b latch=%b", Grant, Busy, Bus_Latch);
    check("rst grant_dropped", 32'(Grant), 32'h0);
    check("rst busy_dropped", 32'(Busy), 32'h0);
    check("rst bus_latch", 32'(Bus_Latch), 32'h0);
    check("rst owner", 32'(Owner), 32'h0);
    Reset = 1'b0;
    tick();
    $display("seq reset regrant: grant=%b owner=%0d", Grant, Owner);
    check("rst regrant", 32'(Grant), 32'h2);
    check("rst regrant_owner", 32'(Owner), 32'h1);
    Request  = 4'b0000;
    Latch_In = 4'b0000;
    tick();
    tick();

    // Owner drops on the same edge master 3 raises its request
    Request = 4'b0001;
    tick();
    check("handover grant0", 32'(Grant), 32'h1);
    Request = 4'b1000;
    tick();
    $display("seq handover release: grant=%b busy=%b", Grant, Busy);
    check("handover release_grant", 32'(Grant), 32'h0);
    check("handover release_busy", 32'(Busy), 32'h0);
    tick();
    check("handover idle_grant", 32'(Grant), 32'h0);
    tick();
    $display("seq handover grant: grant=%b owner=%0d", Grant, Owner);
    check("handover grant3", 32'(Grant), 32'h8);
    check("handover owner3", 32'(Owner), 32'h3);
    Request = 4'b0000;
    tick();
    tick();

`ifdef ARB_TIMEOUT_EN
    // Watchdog: master 1 holds its request past the limit
    Request = 4'b0010;
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("wd hold%0d", i), 32'(Grant), 32'h2);
      check($sformatf("wd flag_low%0d", i), 32'(Timeout_Flag), 32'h0);
      tick();
    end
    $display("seq watchdog release: grant=%b flag=%b", Grant, Timeout_Flag);
    check("wd forced_release", 32'(Grant), 32'h0);
    check("wd flag_pulse", 32'(Timeout_Flag), 32'h1);
    check("wd busy", 32'(Busy), 32'h0);
    tick();
    check("wd flag_cleared", 32'(Timeout_Flag), 32'h0);
    check("wd blocked0", 32'(Grant), 32'h0);
    tick();
    check("wd blocked1", 32'(Grant), 32'h0);
    tick();
    check("wd blocked2", 32'(Grant), 32'h0);
    check("wd flag_once", 32'(Timeout_Flag), 32'h0);
    Request = 4'b0000;
    tick();
    Request = 4'b0010;
    tick();
    $display("seq watchdog regrant: grant=%b", Grant);
    check("wd regrant", 32'(Grant), 32'h2);
    Request = 4'b0000;
    tick();
    tick();
`else
    // Without the watchdog a held request keeps the grant indefinitely
    Request = 4'b0010;
    tick();
    for (int i = 0; i < 40; i++) begin
      check($sformatf("hold grant%0d", i), 32'(Grant), 32'h2);
      check($sformatf("hold flag%0d", i), 32'(Timeout_Flag), 32'h0);
      tick();
    end
    $display("seq hold: grant=%b after 40 cycles", Grant);
    Request = 4'b0000;
    tick();
    check("hold released", 32'(Grant), 32'h0);
    tick();
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
